// File: rtl/vx_ex_router_if.sv
// Handshake bundle between the issue stage, the execution units and the router.
// The router connects through the slave modport; the issue/unit side uses master.
interface vx_ex_router_if #(
    parameter int unsigned ISSUE_WIDTH  = 4,
    parameter int unsigned NUM_UNITS    = 5,
    parameter int unsigned TYPE_W       = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
    parameter int unsigned DISP_W       = 128,
    parameter int unsigned CMT_W        = 128,
    parameter int unsigned MAX_INFLIGHT = 16,
    parameter int unsigned CNT_W        = $clog2(MAX_INFLIGHT + 1)
);
    logic [ISSUE_WIDTH-1:0]                  in_valid;
    logic [ISSUE_WIDTH*TYPE_W-1:0]           in_type;
    logic [ISSUE_WIDTH*DISP_W-1:0]           in_data;
    logic [ISSUE_WIDTH-1:0]                  in_ready;
    logic [NUM_UNITS*ISSUE_WIDTH-1:0]        ex_valid;
    logic [NUM_UNITS*ISSUE_WIDTH*DISP_W-1:0] ex_data;
    logic [NUM_UNITS*ISSUE_WIDTH-1:0]        ex_ready;
    logic [NUM_UNITS*ISSUE_WIDTH-1:0]        cm_in_valid;
    logic [NUM_UNITS*ISSUE_WIDTH*CMT_W-1:0]  cm_in_data;
    logic [NUM_UNITS*ISSUE_WIDTH-1:0]        cm_in_ready;
    logic [ISSUE_WIDTH-1:0]                  cm_out_valid;
    logic [ISSUE_WIDTH*CMT_W-1:0]            cm_out_data;
    logic [ISSUE_WIDTH*TYPE_W-1:0]           cm_out_unit;
    logic [ISSUE_WIDTH-1:0]                  cm_out_ready;
    logic                                    drain;
    logic [ISSUE_WIDTH*CNT_W-1:0]            inflight;
    logic                                    idle;
    logic [1:0]                              err;

    modport master (
        output in_valid, in_type, in_data, ex_ready, cm_in_valid, cm_in_data, cm_out_ready, drain,
        input  in_ready, ex_valid, ex_data, cm_in_ready, cm_out_valid, cm_out_data, cm_out_unit,
               inflight, idle, err
    );

    modport slave (
        input  in_valid, in_type, in_data, ex_ready, cm_in_valid, cm_in_data, cm_out_ready, drain,
        output in_ready, ex_valid, ex_data, cm_in_ready, cm_out_valid, cm_out_data, cm_out_unit,
               inflight, idle, err
    );
endinterface

// File: rtl/vx_ex_router.sv
// Dispatch/commit router: per-(unit, slot) dispatch FIFOs, per-slot round-robin commit
// merge with a registered output stage, and per-slot in-flight tracking.
module vx_ex_router #(
    parameter int unsigned ISSUE_WIDTH  = 4,
    parameter int unsigned NUM_UNITS    = 5,
    parameter int unsigned TYPE_W       = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
    parameter int unsigned DISP_W       = 128,
    parameter int unsigned CMT_W        = 128,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned MAX_INFLIGHT = 16,
    parameter int unsigned CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input logic           clk,
    input logic           reset,
    vx_ex_router_if.slave bus
);
    localparam int unsigned      PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   PtrOne    = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   DepthW    = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
    localparam logic [CNT_W-1:0] MaxCnt    = CNT_W'(MAX_INFLIGHT);
    localparam logic [TYPE_W:0]  NumUnitsW = (TYPE_W + 1)'(NUM_UNITS);

    logic [NUM_UNITS-1:0][ISSUE_WIDTH-1:0][FIFO_DEPTH-1:0][DISP_W-1:0] mem_q, mem_d;
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [NUM_UNITS-1:0][ISSUE_WIDTH-1:0][PTR_W:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [ISSUE_WIDTH-1:0][CNT_W-1:0]  inflight_q, inflight_d;
    logic [ISSUE_WIDTH-1:0][TYPE_W-1:0] rr_q, rr_d, cm_unit_q, cm_unit_d;
    logic [ISSUE_WIDTH-1:0][CMT_W-1:0]  cm_data_q, cm_data_d;
    logic [ISSUE_WIDTH-1:0]             cm_valid_q, cm_valid_d;
    logic [1:0]                         err_q, err_d;

    // Dispatch accept/push, unit-side pop, commit arbitration and in-flight accounting.
    always_comb begin
        logic [TYPE_W-1:0] t;
        logic legal, tgt_full, rdy, inc, dec, found, out_free;
        int unsigned g, idx;

        mem_d      = mem_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        inflight_d = inflight_q;
        rr_d       = rr_q;
        cm_valid_d = cm_valid_q;
        cm_data_d  = cm_data_q;
        cm_unit_d  = cm_unit_q;
        err_d      = err_q;

        bus.in_ready    = '0;
        bus.ex_valid    = '0;
        bus.ex_data     = '0;
        bus.cm_in_ready = '0;

        t        = '0;
        legal    = 1'b0;
        tgt_full = 1'b0;
        rdy      = 1'b0;
        inc      = 1'b0;
        dec      = 1'b0;
        found    = 1'b0;
        out_free = 1'b0;
        g        = 0;
        idx      = 0;

        for (int unsigned s = 0; s < ISSUE_WIDTH; s++) begin
            // Dispatch: readiness uses current occupancy only, never the same-cycle pop.
            t        = bus.in_type[s*TYPE_W +: TYPE_W];
            legal    = {1'b0, t} < NumUnitsW;
            tgt_full = 1'b0;
            for (int unsigned u = 0; u < NUM_UNITS; u++) begin
                if (legal && t == TYPE_W'(u)) begin
                    tgt_full = (wptr_q[u][s] - rptr_q[u][s]) == DepthW;
                end
            end
            rdy = !bus.drain && (inflight_q[s] < MaxCnt) && (!legal || !tgt_full);
            bus.in_ready[s] = rdy;

            inc = 1'b0;
            if (bus.in_valid[s] && rdy) begin
                if (legal) begin
                    inc = 1'b1;
                    for (int unsigned u = 0; u < NUM_UNITS; u++) begin
                        if (t == TYPE_W'(u)) begin
                            mem_d[u][s][wptr_q[u][s][PTR_W-1:0]] = bus.in_data[s*DISP_W +: DISP_W];
                            wptr_d[u][s] = wptr_q[u][s] + PtrOne;
                        end
                    end
                end else begin
                    err_d[0] = 1'b1;
                end
            end

            // Unit side: present FIFO heads, pop on handshake.
            for (int unsigned u = 0; u < NUM_UNITS; u++) begin
                bus.ex_valid[u*ISSUE_WIDTH+s] = wptr_q[u][s] != rptr_q[u][s];
                bus.ex_data[(u*ISSUE_WIDTH+s)*DISP_W +: DISP_W] =
                    mem_q[u][s][rptr_q[u][s][PTR_W-1:0]];
                if ((wptr_q[u][s] != rptr_q[u][s]) && bus.ex_ready[u*ISSUE_WIDTH+s]) begin
                    rptr_d[u][s] = rptr_q[u][s] + PtrOne;
                end
            end

            // Commit merge: first requester at or after the round-robin pointer.
            found = 1'b0;
            g     = 0;
            for (int unsigned k = 0; k < NUM_UNITS; k++) begin
                idx = 32'(rr_q[s]) + k;
                if (idx >= NUM_UNITS) idx = idx - NUM_UNITS;
                if (!found && bus.cm_in_valid[idx*ISSUE_WIDTH+s]) begin
                    found = 1'b1;
                    g     = idx;
                end
            end
            out_free = !cm_valid_q[s] || bus.cm_out_ready[s];
            dec      = found && out_free;
            if (dec) begin
                bus.cm_in_ready[g*ISSUE_WIDTH+s] = 1'b1;
                cm_valid_d[s] = 1'b1;
                cm_data_d[s]  = bus.cm_in_data[(g*ISSUE_WIDTH+s)*CMT_W +: CMT_W];
                cm_unit_d[s]  = TYPE_W'(g);
                rr_d[s]       = (g + 1 >= NUM_UNITS) ? '0 : TYPE_W'(g + 1);
            end else if (bus.cm_out_ready[s]) begin
                cm_valid_d[s] = 1'b0;
            end

            // In-flight: coincident increment and decrement cancel out.
            if (inc && !dec) begin
                inflight_d[s] = inflight_q[s] + CntOne;
            end else if (dec && !inc) begin
                if (inflight_q[s] == '0) err_d[1] = 1'b1;
                else                     inflight_d[s] = inflight_q[s] - CntOne;
            end
        end
    end

    // Idle when nothing is buffered, in flight, or waiting at the commit output.
    always_comb begin
        bus.idle = (cm_valid_q == '0) && (inflight_q == '0) && (wptr_q == rptr_q);
    end

    assign bus.inflight     = inflight_q;
    assign bus.cm_out_valid = cm_valid_q;
    assign bus.cm_out_data  = cm_data_q;
    assign bus.cm_out_unit  = cm_unit_q;
    assign bus.err          = err_q;

    // State update; payload storage needs no reset since pointers gate its visibility.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (!reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            inflight_q <= '0;
            rr_q       <= '0;
            cm_valid_q <= '0;
            cm_data_q  <= '0;
            cm_unit_q  <= '0;
            err_q      <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            inflight_q <= inflight_d;
            rr_q       <= rr_d;
            cm_valid_q <= cm_valid_d;
            cm_data_q  <= cm_data_d;
            cm_unit_q  <= cm_unit_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_vx_ex_router.sv
// Directed testbench for vx_ex_router with the default configuration
// (4 slots, 5 units, depth-2 FIFOs, in-flight limit 16).
module tb_vx_ex_router;
    localparam int unsigned IW = 4;
    localparam int unsigned DW = 128;
    localparam int unsigned CW = 128;

    logic        clk;
    logic        reset;
    int unsigned pass_cnt;
    int unsigned total_cnt;

    vx_ex_router_if bus ();

    vx_ex_router dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.in_valid     = '0;
        bus.in_type      = '0;
        bus.in_data      = '0;
        bus.ex_ready     = '0;
        bus.cm_in_valid  = '0;
        bus.cm_in_data   = '0;
        bus.cm_out_ready = '0;
        bus.drain        = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset            = 1'b0;
        bus.in_valid     = 4'($urandom);
        bus.in_type      = 12'($urandom);
        bus.in_data      = {16{$urandom()}};
        bus.ex_ready     = 20'($urandom);
        bus.cm_in_valid  = 20'($urandom);
        bus.cm_in_data   = {80{$urandom()}};
        bus.cm_out_ready = 4'($urandom);
        bus.drain        = 1'($urandom);
        tick();
        tick();
        total_cnt++;
        if (bus.ex_valid !== 20'd0) $display("FAIL rst_ex_valid: got %h want %h", bus.ex_valid, 20'd0);
        else pass_cnt++;
        total_cnt++;
        if (bus.cm_out_valid !== 4'd0) $display("FAIL rst_cm_valid: got %h want 0", bus.cm_out_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.inflight !== 20'd0) $display("FAIL rst_inflight: got %h want 0", bus.inflight);
        else pass_cnt++;
        total_cnt++;
        if (bus.err !== 2'b00) $display("FAIL rst_err: got %b want 00", bus.err);
        else pass_cnt++;
        total_cnt++;
        if (bus.idle !== 1'b1) $display("FAIL rst_idle: got %b want 1", bus.idle);
        else pass_cnt++;
        reset = 1'b1;
        clear_inputs();
        #1;
        total_cnt++;
        if (bus.in_ready !== 4'hf) $display("FAIL rst_in_ready: got %h want f", bus.in_ready);
        else pass_cnt++;
    endtask

    task automatic test_routing();
        logic [DW-1:0] d0, d1, d2;
        d0 = 128'h1111_0000;
        d1 = 128'h2222_0001;
        d2 = 128'h3333_0002;
        do_reset();
        bus.in_valid[1]       = 1'b1;
        bus.in_type[3 +: 3]   = 3'd3;
        bus.in_data[DW +: DW] = d0;
        #1;
        total_cnt++;
        if (bus.in_ready[1] !== 1'b1) $display("FAIL route_acc0: got %b want 1", bus.in_ready[1]);
        else pass_cnt++;
        tick();
        bus.in_data[DW +: DW] = d1;
        #1;
        total_cnt++;
        if (bus.in_ready[1] !== 1'b1) $display("FAIL route_acc1: got %b want 1", bus.in_ready[1]);
        else pass_cnt++;
        total_cnt++;
        if (bus.ex_valid !== 20'h02000)
            $display("FAIL route_latency: ex_valid got %h want %h", bus.ex_valid, 20'h02000);
        else pass_cnt++;
        total_cnt++;
        if (bus.ex_data[13*DW +: DW] !== d0)
            $display("FAIL route_head0: got %h want %h", bus.ex_data[13*DW +: DW], d0);
        else pass_cnt++;
        tick();
        bus.in_data[DW +: DW] = d2;
        #1;
        total_cnt++;
        if (bus.in_ready[1] !== 1'b0) $display("FAIL route_full: got %b want 0", bus.in_ready[1]);
        else pass_cnt++;
        tick();
        bus.ex_ready[13] = 1'b1;
        #1;
        total_cnt++;
        if (bus.in_ready[1] !== 1'b0)
            $display("FAIL route_no_bypass: in_ready got %b want 0", bus.in_ready[1]);
        else pass_cnt++;
        total_cnt++;
        if (bus.ex_data[13*DW +: DW] !== d0)
            $display("FAIL route_pop0: got %h want %h", bus.ex_data[13*DW +: DW], d0);
        else pass_cnt++;
        tick();
        #1;
        total_cnt++;
        if (bus.in_ready[1] !== 1'b1)
            $display("FAIL route_acc2: in_ready got %b want 1", bus.in_ready[1]);
        else pass_cnt++;
        total_cnt++;
        if (bus.ex_data[13*DW +: DW] !== d1)
            $display("FAIL route_pop1: got %h want %h", bus.ex_data[13*DW +: DW], d1);
        else pass_cnt++;
        tick();
        bus.in_valid[1] = 1'b0;
        #1;
        total_cnt++;
        if (bus.ex_valid[13] !== 1'b1 || bus.ex_data[13*DW +: DW] !== d2)
            $display("FAIL route_pop2: valid %b data %h want 1 %h",
                     bus.ex_valid[13], bus.ex_data[13*DW +: DW], d2);
        else pass_cnt++;
        total_cnt++;
        if (bus.inflight[5 +: 5] !== 5'd3)
            $display("FAIL route_inflight: got %0d want 3", bus.inflight[5 +: 5]);
        else pass_cnt++;
        tick();
        #1;
        total_cnt++;
        if (bus.ex_valid !== 20'd0) $display("FAIL route_empty: got %h want 0", bus.ex_valid);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        int unsigned   rr_seq [6] = '{0, 2, 4, 0, 2, 4};
        logic [19:0]   exp_rdy;
        logic [CW-1:0] exp_data;
        do_reset();
        for (int u = 0; u < 5; u++) bus.cm_in_data[(u*IW)*CW +: CW] = 128'ha0 + 128'(u);
        bus.cm_in_valid[0]  = 1'b1;
        bus.cm_in_valid[8]  = 1'b1;
        bus.cm_in_valid[16] = 1'b1;
        bus.cm_out_ready[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_rdy  = 20'd1 << (rr_seq[i] * IW);
            exp_data = 128'ha0 + 128'(rr_seq[i]);
            #1;
            total_cnt++;
            if (bus.cm_in_ready !== exp_rdy)
                $display("FAIL rr_grant%0d: got %h want %h", i, bus.cm_in_ready, exp_rdy);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (bus.cm_out_valid[0] !== 1'b1 || bus.cm_out_unit[2:0] !== 3'(rr_seq[i]) ||
                bus.cm_out_data[0 +: CW] !== exp_data)
                $display("FAIL rr_out%0d: valid %b unit %0d data %h want 1 %0d %h", i,
                         bus.cm_out_valid[0], bus.cm_out_unit[2:0], bus.cm_out_data[0 +: CW],
                         rr_seq[i], exp_data);
            else pass_cnt++;
        end
    endtask

    task automatic test_output_stall();
        bus.cm_out_ready[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++;
            if (bus.cm_in_ready !== 20'd0)
                $display("FAIL stall_grant%0d: got %h want 0", i, bus.cm_in_ready);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (bus.cm_out_valid[0] !== 1'b1 || bus.cm_out_unit[2:0] !== 3'd4 ||
                bus.cm_out_data[0 +: CW] !== 128'ha4)
                $display("FAIL stall_hold%0d: valid %b unit %0d data %h want 1 4 a4", i,
                         bus.cm_out_valid[0], bus.cm_out_unit[2:0], bus.cm_out_data[0 +: CW]);
            else pass_cnt++;
        end
        bus.cm_out_ready[0] = 1'b1;
        #1;
        total_cnt++;
        if (bus.cm_in_ready !== 20'd1)
            $display("FAIL stall_release: got %h want %h", bus.cm_in_ready, 20'd1);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.cm_out_unit[2:0] !== 3'd0)
            $display("FAIL stall_next_unit: got %0d want 0", bus.cm_out_unit[2:0]);
        else pass_cnt++;
        clear_inputs();
    endtask

    task automatic test_inflight_drain();
        do_reset();
        bus.in_valid[2]      = 1'b1;
        bus.in_type[6 +: 3]  = 3'd0;
        bus.in_data[2*DW +: DW] = 128'h55;
        bus.ex_ready[2]      = 1'b1;
        bus.cm_out_ready[2]  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            total_cnt++;
            if (bus.in_ready[2] !== 1'b1) $display("FAIL lim_accept%0d: got 0 want 1", i);
            else pass_cnt++;
            tick();
        end
        #1;
        total_cnt++;
        if (bus.inflight[10 +: 5] !== 5'd16)
            $display("FAIL lim_count: got %0d want 16", bus.inflight[10 +: 5]);
        else pass_cnt++;
        total_cnt++;
        if (bus.in_ready[2] !== 1'b0) $display("FAIL lim_ready: got %b want 0", bus.in_ready[2]);
        else pass_cnt++;
        bus.cm_in_valid[2] = 1'b1;
        #1;
        total_cnt++;
        if (bus.in_ready[2] !== 1'b0)
            $display("FAIL lim_ready_cm: got %b want 0", bus.in_ready[2]);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.inflight[10 +: 5] !== 5'd15 || bus.in_ready[2] !== 1'b1)
            $display("FAIL lim_dec: count %0d ready %b want 15 1",
                     bus.inflight[10 +: 5], bus.in_ready[2]);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.inflight[10 +: 5] !== 5'd15)
            $display("FAIL lim_simul: got %0d want 15", bus.inflight[10 +: 5]);
        else pass_cnt++;
        bus.cm_in_valid[2] = 1'b0;
        tick();
        total_cnt++;
        if (bus.inflight[10 +: 5] !== 5'd16)
            $display("FAIL lim_refill: got %0d want 16", bus.inflight[10 +: 5]);
        else pass_cnt++;
        bus.in_valid[2]    = 1'b0;
        bus.drain          = 1'b1;
        bus.in_valid       = 4'hf;
        bus.cm_in_valid[2] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            total_cnt++;
            if (bus.in_ready !== 4'h0) $display("FAIL drain_ready%0d: got %h want 0", i, bus.in_ready);
            else pass_cnt++;
            tick();
        end
        bus.cm_in_valid[2] = 1'b0;
        #1;
        total_cnt++;
        if (bus.inflight[10 +: 5] !== 5'd0 || bus.idle !== 1'b0)
            $display("FAIL drain_count: count %0d idle %b want 0 0",
                     bus.inflight[10 +: 5], bus.idle);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.idle !== 1'b1 || bus.err !== 2'b00)
            $display("FAIL drain_idle: idle %b err %b want 1 00", bus.idle, bus.err);
        else pass_cnt++;
        clear_inputs();
    endtask

    task automatic test_errors();
        do_reset();
        bus.in_valid[0]     = 1'b1;
        bus.in_type[0 +: 3] = 3'd7;
        #1;
        total_cnt++;
        if (bus.in_ready[0] !== 1'b1) $display("FAIL err_ill_ready: got %b want 1", bus.in_ready[0]);
        else pass_cnt++;
        tick();
        bus.in_valid[0] = 1'b0;
        #1;
        total_cnt++;
        if (bus.ex_valid !== 20'd0 || bus.err !== 2'b01 || bus.inflight[0 +: 5] !== 5'd0)
            $display("FAIL err_illegal: ex_valid %h err %b count %0d want 0 01 0",
                     bus.ex_valid, bus.err, bus.inflight[0 +: 5]);
        else pass_cnt++;
        bus.cm_in_valid[7]     = 1'b1;
        bus.cm_in_data[7*CW +: CW] = 128'hbeef;
        bus.cm_out_ready[3]    = 1'b1;
        #1;
        total_cnt++;
        if (bus.cm_in_ready !== 20'h00080)
            $display("FAIL err_cm_grant: got %h want %h", bus.cm_in_ready, 20'h00080);
        else pass_cnt++;
        tick();
        bus.cm_in_valid[7] = 1'b0;
        #1;
        total_cnt++;
        if (bus.err !== 2'b11 || bus.inflight[15 +: 5] !== 5'd0)
            $display("FAIL err_underflow: err %b count %0d want 11 0",
                     bus.err, bus.inflight[15 +: 5]);
        else pass_cnt++;
        total_cnt++;
        if (bus.cm_out_unit[9 +: 3] !== 3'd1 || bus.cm_out_data[3*CW +: CW] !== 128'hbeef)
            $display("FAIL err_cm_out: unit %0d data %h want 1 beef",
                     bus.cm_out_unit[9 +: 3], bus.cm_out_data[3*CW +: CW]);
        else pass_cnt++;
        bus.in_valid[0]     = 1'b1;
        bus.in_type[0 +: 3] = 3'd1;
        tick();
        bus.cm_in_valid[7] = 1'b1;
        reset = 1'b0;
        tick();
        total_cnt++;
        if (bus.err !== 2'b00 || bus.ex_valid !== 20'd0 || bus.cm_out_valid !== 4'd0 ||
            bus.inflight !== 20'd0 || bus.idle !== 1'b1)
            $display("FAIL err_mid_reset: err %b ex %h cmv %h infl %h idle %b want 00 0 0 0 1",
                     bus.err, bus.ex_valid, bus.cm_out_valid, bus.inflight, bus.idle);
        else pass_cnt++;
        reset = 1'b1;
        clear_inputs();
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b0;
        clear_inputs();
        test_reset();
        test_routing();
        test_round_robin();
        test_output_stall();
        test_inflight_drain();
        test_errors();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
